// File: rtl/cv32e40p_ldm_pkg.sv
// Shared definitions for the LDM detector and its alarm handler.
package cv32e40p_ldm_pkg;

  // Alarm handler states
  typedef enum logic [2:0] {
    LdmIdle,
    LdmReq,
    LdmReinit,
    LdmBlank,
    LdmLock
  } ldm_alarm_state_e;

  // Defaults shared with the detector's MAX_BB_LEN / MAX_INSTR_EXE_CYCLES
  localparam int unsigned LDM_LOCK_THRESHOLD = 3;
  localparam int unsigned LDM_ACK_TIMEOUT    = 16;
  localparam int unsigned LDM_CNT_WIDTH      = 4;

endpackage

// File: rtl/cv32e40p_ldm_alarm_handler.sv
// LDM alarm handler: turns detector alarms into core interrupts, re-initialises the
// detector after acknowledge and escalates to a permanent halt on repeated alarms or a
// missing acknowledge.
module cv32e40p_ldm_alarm_handler
  import cv32e40p_ldm_pkg::*;
#(
  parameter int unsigned LOCK_THRESHOLD = LDM_LOCK_THRESHOLD,
  parameter int unsigned ACK_TIMEOUT    = LDM_ACK_TIMEOUT,
  parameter int unsigned CNT_WIDTH      = LDM_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alarm_i,
  input  logic                 alarm_en_i,
  input  logic                 clear_i,
  input  logic                 irq_ack_i,
  output logic                 irq_o,
  output logic                 det_init_o,
  output logic                 halt_o,
  output logic                 alarm_sticky_o,
  output logic                 overrun_o,
  output logic [CNT_WIDTH-1:0] alarm_cnt_o
);

  localparam int unsigned          TmoWidth = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TmoWidth-1:0]  TmoLoad  = TmoWidth'(ACK_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CntMax   = {CNT_WIDTH{1'b1}};

  ldm_alarm_state_e      state_q;
  logic                  alarm_q;
  logic                  rise;
  logic [TmoWidth-1:0]   tmo_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_inc;
  logic                  lock_hit;
  logic                  sticky_q;
  logic                  overrun_q;

  assign rise     = alarm_i & ~alarm_q;
  // Saturating increment; the lockdown decision uses the post-increment count
  assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_WIDTH'(1);
  assign lock_hit = 32'(cnt_inc) >= LOCK_THRESHOLD;

  // Alarm edge detector: only rising edges start a service
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_i;
    end
  end

  // Service FSM with alarm counter, sticky flags and acknowledge timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LdmIdle;
      tmo_q     <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      unique case (state_q)
        LdmIdle: begin
          if (rise && alarm_en_i) begin
            cnt_q    <= cnt_inc;
            sticky_q <= 1'b1;
            if (lock_hit) begin
              state_q <= LdmLock;
            end else begin
              state_q <= LdmReq;
              tmo_q   <= TmoLoad;
            end
          end else if (clear_i && !rise) begin
            // A rise (even a disabled one) takes precedence over software clear
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            overrun_q <= 1'b0;
          end
        end
        LdmReq: begin
          if (rise) overrun_q <= 1'b1;
          // Ack wins over a timeout expiring in the same cycle
          if (irq_ack_i) begin
            state_q <= LdmReinit;
            tmo_q   <= '0;
          end else if (tmo_q <= TmoWidth'(1)) begin
            state_q <= LdmLock;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_q - TmoWidth'(1);
          end
        end
        LdmReinit: begin
          if (rise) overrun_q <= 1'b1;
          state_q <= LdmBlank;
        end
        // Detector alarm falls one cycle after init; rises here are ignored
        LdmBlank: state_q <= LdmIdle;
        LdmLock:  state_q <= LdmLock;
        default:  state_q <= LdmIdle;
      endcase
    end
  end

  assign irq_o          = (state_q == LdmReq);
  assign det_init_o     = (state_q == LdmReinit);
  assign halt_o         = (state_q == LdmLock);
  assign alarm_sticky_o = sticky_q;
  assign overrun_o      = overrun_q;
  assign alarm_cnt_o    = cnt_q;

endmodule

// File: tb/tb_cv32e40p_ldm_alarm_handler.sv
// Scoreboard bench for the LDM alarm handler with directed vectors.
module tb_cv32e40p_ldm_alarm_handler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alarm, en, clr, ack;
  logic       irq, det, halt, sticky, ovr;
  logic [3:0] cnt;
  logic [9:0] dut_vec;

  int cyc    = 0;
  int base   = 0;
  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int         cyc;
    logic [9:0] v;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  cv32e40p_ldm_alarm_handler #(
    .LOCK_THRESHOLD(3),
    .ACK_TIMEOUT   (16),
    .CNT_WIDTH     (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alarm_i       (alarm),
    .alarm_en_i    (en),
    .clear_i       (clr),
    .irq_ack_i     (ack),
    .irq_o         (irq),
    .det_init_o    (det),
    .halt_o        (halt),
    .alarm_sticky_o(sticky),
    .overrun_o     (ovr),
    .alarm_cnt_o   (cnt)
  );

  assign dut_vec = {irq, det, halt, sticky, ovr, cnt};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] o(logic i, logic d, logic h, logic s, logic v, logic [3:0] c);
    return {i, d, h, s, v, c};
  endfunction

  task automatic check(string nm, logic [9:0] act, logic [9:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got irq,det,halt,sticky,ovr,cnt=%b required %b", nm, act, req);
  endtask

  task automatic ex(int dc, logic [9:0] v, string nm);
    exp_t e;
    e.cyc = base + dc;
    e.v   = v;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: compares DUT outputs against queued expectations mid-cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc < cyc) check({mon_e.nm, "_missed"}, 10'h3ff, mon_e.v);
      else check(mon_e.nm, dut_vec, mon_e.v);
    end
  end

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge
  task automatic async_reset(string nm);
    drain();
    alarm = 1'b0; en = 1'b1; clr = 1'b0; ack = 1'b0;
    #2 rst_n = 1'b0;
    #1 check({"async_rst_", nm}, dut_vec, 10'b0);
    ticks(2);
    rst_n = 1'b1;
    tick();
  endtask

  // One alarm serviced with ack after three REQ cycles
  task automatic alarm_acked(logic [3:0] c, logic v, string nm);
    base = cyc;
    ex(1, o(1, 0, 0, 1, v, c), {nm, "_req1"});
    ex(2, o(1, 0, 0, 1, v, c), {nm, "_req2"});
    ex(3, o(1, 0, 0, 1, v, c), {nm, "_req3"});
    ex(4, o(0, 1, 0, 1, v, c), {nm, "_reinit"});
    ex(5, o(0, 0, 0, 1, v, c), {nm, "_blank"});
    ex(6, o(0, 0, 0, 1, v, c), {nm, "_idle"});
    alarm = 1'b1; tick();
    alarm = 1'b0; ticks(2);
    ack = 1'b1; tick();
    ack = 1'b0; ticks(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; alarm = 1'b0; en = 1'b1; clr = 1'b0; ack = 1'b0;
    ticks(3);
    check("por", dut_vec, 10'b0);
    rst_n = 1'b1;
    tick();
    base = cyc;
    ex(0, 10'b0, "idle_after_reset");

    // Single alarm, then threshold lockdown on the third
    alarm_acked(4'd1, 1'b0, "a1");
    alarm_acked(4'd2, 1'b0, "a2");
    base = cyc;
    ex(1, o(0, 0, 1, 1, 0, 3), "lock_third");
    ex(3, o(0, 0, 1, 1, 0, 3), "lock_ignores_clr");
    alarm = 1'b1; tick();
    alarm = 1'b0; clr = 1'b1; ack = 1'b1; tick();
    alarm = 1'b1; tick();
    alarm = 1'b0; clr = 1'b0; ack = 1'b0;
    async_reset("lock");

    // Ack timeout: 16 REQ cycles then lockdown
    base = cyc;
    ex(1,  o(1, 0, 0, 1, 0, 1), "tmo_first");
    ex(16, o(1, 0, 0, 1, 0, 1), "tmo_last");
    ex(17, o(0, 0, 1, 1, 0, 1), "tmo_lock");
    alarm = 1'b1; tick();
    alarm = 1'b0; ticks(16);
    async_reset("tmo_lock");

    // Ack on the 16th REQ cycle beats the timeout
    base = cyc;
    ex(16, o(1, 0, 0, 1, 0, 1), "ack16_req");
    ex(17, o(0, 1, 0, 1, 0, 1), "ack16_reinit");
    ex(18, o(0, 0, 0, 1, 0, 1), "ack16_blank");
    alarm = 1'b1; tick();
    alarm = 1'b0; ticks(15);
    ack = 1'b1; tick();
    ack = 1'b0; ticks(2);

    // Overrun during REQ, then clear after two alarms
    base = cyc;
    ex(1, o(1, 0, 0, 1, 0, 2), "ovr_req");
    ex(3, o(1, 0, 0, 1, 1, 2), "ovr_set");
    ex(5, o(0, 1, 0, 1, 1, 2), "ovr_reinit");
    ex(8, o(0, 0, 0, 0, 0, 0), "clear");
    alarm = 1'b1; tick();
    alarm = 1'b0; tick();
    alarm = 1'b1; tick();
    alarm = 1'b0; tick();
    ack = 1'b1; tick();
    ack = 1'b0; ticks(2);
    clr = 1'b1; tick();
    clr = 1'b0;

    // Level held through REINIT/BLANK must not retrigger
    base = cyc;
    ex(1,  o(1, 0, 0, 1, 0, 1), "hold_req");
    ex(4,  o(0, 1, 0, 1, 0, 1), "hold_reinit");
    ex(7,  o(0, 0, 0, 1, 0, 1), "hold_no_retrig");
    ex(9,  o(0, 0, 0, 1, 0, 1), "hold_no_retrig2");
    ex(11, o(1, 0, 0, 1, 0, 2), "rearm_req");
    ex(12, o(0, 1, 0, 1, 0, 2), "rearm_reinit");
    ex(14, o(0, 0, 0, 1, 0, 2), "rearm_idle");
    alarm = 1'b1; ticks(3);
    ack = 1'b1; tick();
    ack = 1'b0; ticks(5);
    alarm = 1'b0; tick();
    alarm = 1'b1; tick();
    alarm = 1'b0; ack = 1'b1; tick();
    ack = 1'b0; ticks(2);

    // Clear, disabled alarm, clear coincident with rise
    base = cyc;
    ex(1, 10'b0, "clear2");
    ex(2, 10'b0, "en_off");
    ex(3, 10'b0, "en_off2");
    ex(4, o(1, 0, 0, 1, 0, 1), "clr_rise");
    ex(5, o(0, 1, 0, 1, 0, 1), "clr_rise_reinit");
    clr = 1'b1; tick();
    clr = 1'b0; en = 1'b0; alarm = 1'b1; tick();
    alarm = 1'b0; en = 1'b1; tick();
    alarm = 1'b1; clr = 1'b1; tick();
    alarm = 1'b0; clr = 1'b0; ack = 1'b1; tick();
    ack = 1'b0; ticks(2);

    // Reset while in REQ, then normal operation resumes
    base = cyc;
    ex(1, o(1, 0, 0, 1, 0, 2), "pre_rst_req");
    alarm = 1'b1; tick();
    alarm = 1'b0; tick();
    async_reset("req");
    alarm_acked(4'd1, 1'b0, "resume");
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cv32e40p_ldm_alarm_handler.md
Name: cv32e40p_ldm_alarm_handler

Overview:
- Sits directly downstream of the LDM detector and consumes its alarm output.
- Turns each new alarm into an interrupt request to the core controller, then waits for acknowledge.
- Re-initialises the detector once the alarm is acknowledged.
- Counts alarms and escalates to a permanent core halt (lockdown) on repeated alarms or on a missing acknowledge.

Parameters:
- LOCK_THRESHOLD, 3, number of counted alarms that forces lockdown; legal range 1..2**CNT_WIDTH-1.
- ACK_TIMEOUT, 16, cycles allowed in REQ without irq_ack_i before lockdown; must be >= 1.
- CNT_WIDTH, 4, width of the saturating alarm counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- alarm_i  in  1  level alarm from the LDM detector
- alarm_en_i  in  1  1 = alarms are handled; 0 = alarm edges are ignored
- clear_i  in  1  software clear of the count and sticky flags; honoured in IDLE only
- irq_ack_i  in  1  controller acknowledge of irq_o
- irq_o  out  1  interrupt request, held high while in REQ
- det_init_o  out  1  one-cycle pulse, driven to the detector's init_i
- halt_o  out  1  kill fetch and halt the core; sticky until reset
- alarm_sticky_o  out  1  at least one alarm handled since the last clear
- overrun_o  out  1  sticky; an alarm edge arrived while one was already in service
- alarm_cnt_o  out  CNT_WIDTH  count of handled alarms

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, all outputs 0, alarm_q=0, timeout counter=0.
  - Asserting rst_n mid-operation aborts the current state immediately, including LOCK.
- Edge detect: alarm_q <= alarm_i every cycle; rise = alarm_i & ~alarm_q. Only rising edges are acted on; a level held high never re-triggers.
- States: IDLE, REQ, REINIT, BLANK, LOCK. All outputs are registered or decoded from the registered state.
- IDLE:
  - rise & alarm_en_i: alarm_cnt += 1 (saturating at 2**CNT_WIDTH-1) and alarm_sticky_o <= 1.
  - If the new count >= LOCK_THRESHOLD, next state is LOCK; otherwise next state is REQ and the timeout counter loads ACK_TIMEOUT.
  - clear_i & no rise: alarm_cnt <= 0, alarm_sticky_o <= 0, overrun_o <= 0.
  - clear_i & rise in the same cycle: the rise wins and clear_i is dropped.
- REQ:
  - irq_o=1.
  - irq_ack_i → REINIT. The ack is sampled in the same cycle, so irq_o deasserts on the cycle after the ack.
  - Otherwise the timeout counter decrements; it reaching 0 with no ack → LOCK.
  - An ack arriving on the same cycle the counter reaches 0 wins: go to REINIT.
- REINIT: det_init_o=1 for exactly one cycle → BLANK.
- BLANK:
  - One cycle; rise is ignored here, because the detector alarm falls one cycle after init → IDLE.
  - alarm_i still high on leaving BLANK does not create a rise. The next alarm must deassert and reassert.
- Any rise in REQ or REINIT: overrun_o <= 1; no count change, no state change.
- LOCK:
  - halt_o=1 and irq_o=0.
  - clear_i, irq_ack_i and alarm_i are ignored; only rst_n exits.
- alarm_en_i=0: rises are ignored in IDLE only. A service already in progress completes normally.
- irq_ack_i outside REQ is ignored.

Decomposition:
- Shared package cv32e40p_ldm_pkg holds:
  - ldm_alarm_state_e, the state enum encoding the five states;
  - default constants LDM_LOCK_THRESHOLD and LDM_ACK_TIMEOUT, shared with the detector's MAX_BB_LEN / MAX_INSTR_EXE_CYCLES defaults.
- No sub-module: the edge detect, timeout counter and FSM live in one module.
- Width of the timeout counter = $clog2(ACK_TIMEOUT+1).

Test Plan:
- Single alarm, defaults:
  - Stimulus: alarm_i rises at cycle 10; irq_ack_i at cycle 13.
  - Response: irq_o high cycles 11-13; det_init_o pulse at cycle 14; alarm_cnt_o=1; alarm_sticky_o=1; back in IDLE at cycle 16.
- Threshold lockdown: three separated alarms, each acked.
  - Response: the third alarm goes directly to LOCK; halt_o=1, irq_o never asserted for it, alarm_cnt_o=3.
  - clear_i then has no effect.
- Ack timeout: one alarm, no ack.
  - Response: irq_o high for 16 cycles, then halt_o=1.
  - Ack exactly on the 16th cycle → REINIT; halt_o stays 0.
- Overrun and level-hold:
  - alarm_i pulse while in REQ → overrun_o=1, count unchanged.
  - alarm_i held high through REINIT/BLANK → no second REQ until it drops and rises again.
- Clear and enable:
  - clear_i in IDLE after two alarms → count=0, sticky=0, overrun_o=0.
  - alarm_en_i=0 with an alarm rise → no irq_o, count stays 0.
  - clear_i coincident with a rise → count=1.
- Async reset in REQ and in LOCK: every output reads 0 without waiting for a clock edge; operation resumes normally after rst_n=1.
